menu_state_ctrl: RTL
====================

// Module: menu_state_ctrl
// PURPOSE
//   Consumes the 2-bit menu selection index and confirm/back button pulses.
//   Drives the 4-bit system state code back to the menu renderer and to the app blocks.
//   Enters the selected app on confirm and returns to the menu on back or app request.
//   Every transition inserts a fixed blanking window so the OLED never shows a torn frame.
// PARAMETERS
//   SETTLE_CYCLES      1024    cycles of blanking per transition; legal range >=1
//   LONG_PRESS_CYCLES  6250000 cycles btnL must be held to exit; used only with LONG_PRESS_EXIT_EN
// PORTS
//   CLOCK        in   1  system clock; the only clock
//   reset        in   1  synchronous, active-high reset
//   menu_sel     in   2  current highlighted menu item, 0..3
//   btnC_pulse   in   1  one-cycle confirm pulse
//   btnL_pulse   in   1  one-cycle back pulse
//   btnL_level   in   1  debounced btnL level; used only with LONG_PRESS_EXIT_EN
//   app_done     in   1  one-cycle request from the active app to return to the menu
//   state        out  4  0x0 = menu; 0x1..0x4 = app (sel+1); 0xF = transit
//   blank        out  1  high while in transit; OLED drives black
//   state_chg    out  1  one-cycle pulse on the cycle state takes a new stable value
// BEHAVIOUR
//   - Reset: FSM=MENU, state=0x0, blank=0, state_chg=0, sel_q=0, counter=0.
//     Reset overrides everything, including mid-transit.
//   - FSM states: MENU, ENTER, APP, EXIT. All state/counter updates happen on the CLOCK rising edge.
//   - MENU: btnC_pulse -> latch sel_q<=menu_sel, cnt<=0, go ENTER. btnL_pulse and app_done are ignored.
//   - ENTER: state=0xF, blank=1. Increment cnt. When cnt==SETTLE_CYCLES-1, go APP.
//     Update state<=sel_q+1 and pulse state_chg in the same edge.
//   - APP: state=sel_q+1, blank=0. An exit event -> cnt<=0, go EXIT. btnC_pulse is ignored.
//   - EXIT: state=0xF, blank=1. Count as in ENTER. On completion go MENU.
//     Update state<=0x0 and pulse state_chg in the same edge.
//   - Latency: confirm edge to stable app state = SETTLE_CYCLES+1 edges.
//     blank rises on the edge after the pulse.
//   - Inputs during ENTER/EXIT: all are ignored. menu_sel changes after confirm do not affect sel_q.
//   - Simultaneous btnL exit and app_done in APP: a single exit; no queued second event.
//   - state_chg is never high in two consecutive cycles. It is 0 in transit and on reset release.
//   - Arithmetic: state = {2'b00, sel_q} + 1, 4-bit. No wrap is possible (max 0x4).
//     cnt width = $clog2(SETTLE_CYCLES+1).
// CONFIGURATION
//   LONG_PRESS_EXIT_EN defined:
//     - Exit event = btnL_level held high for LONG_PRESS_CYCLES consecutive cycles while in APP,
//       or app_done. btnL_pulse is ignored.
//     - The hold counter clears whenever btnL_level=0 or FSM!=APP.
//     - The hold counter fires once per hold and re-arms only after btnL_level returns to 0.
//   LONG_PRESS_EXIT_EN undefined:
//     - Exit event = btnL_pulse or app_done.
//     - btnL_level is unused and no hold counter is built.
// STRUCTURE
//   Package menu_pkg:
//     - ST_MENU=4'h0, ST_APP_BASE=4'h1, ST_TRANSIT=4'hF.
//     - FSM enum {MENU, ENTER, APP, EXIT}; NUM_MENU_ITEMS=4.
//   Sub-module press_hold_timer, instantiated only under LONG_PRESS_EXIT_EN:
//     - Ports: level, enable, count, one-cycle fire output.
//   Everything else is in this module.
// TESTING (SETTLE_CYCLES=4, LONG_PRESS_CYCLES=8 in bench)
//   1. Reset release: state=0x0, blank=0, state_chg=0 for 10 cycles with no input.
//   2. Enter: menu_sel=2, btnC_pulse at cycle 0.
//      -> blank=1 and state=0xF in cycles 1-4; state=0x3 and state_chg=1 at cycle 5.
//   3. Select change in transit: menu_sel 2->0 during ENTER -> final state is still 0x3.
//   4. Exit (macro off): in APP, btnL_pulse and app_done in the same cycle.
//      -> one EXIT; state=0x0 after 5 edges; exactly one state_chg.
//   5. Exit (macro on): btnL_level high 7 cycles then low -> stay in APP.
//      Held high 8 cycles -> EXIT begins the next edge.
//   6. Reset mid-transit: assert reset in cycle 2 of ENTER.
//      -> state=0x0, blank=0 on the next edge; a later confirm enters normally.

Source files
------------

// File: rtl/menu_pkg.sv
// Shared definitions for the menu/app state controller.
//   ST_MENU / ST_APP_BASE / ST_TRANSIT : 4-bit system state codes
//   fsm_t                              : controller FSM states
//   app_code()                         : state code for a given menu item
package menu_pkg;

    localparam int unsigned NUM_MENU_ITEMS = 4;
    localparam int unsigned SEL_W          = $clog2(NUM_MENU_ITEMS);
    localparam int unsigned STATE_W        = 4;

    localparam logic [STATE_W-1:0] ST_MENU     = 4'h0;
    localparam logic [STATE_W-1:0] ST_APP_BASE = 4'h1;
    localparam logic [STATE_W-1:0] ST_TRANSIT  = 4'hF;

    typedef enum logic [1:0] {
        MENU,
        ENTER,
        APP,
        EXIT
    } fsm_t;

    // App state code: menu item 0..3 maps onto 0x1..0x4, no wrap possible.
    function automatic logic [STATE_W-1:0] app_code(input logic [SEL_W-1:0] sel);
        return {{(STATE_W-SEL_W){1'b0}}, sel} + ST_APP_BASE;
    endfunction

endpackage

// File: rtl/press_hold_timer.sv
// Long-press detector for the back button.
// Counts consecutive cycles of 'level' while 'enable' is high and raises
// 'fire' for exactly one cycle once HOLD_CYCLES have been seen. After firing
// it stays quiet until 'level' drops, so one hold produces one event.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   level      : debounced button level
//   enable     : counting allowed (controller is in an app)
//   count      : current hold count
//   fire       : one-cycle long-press event (registered)
module press_hold_timer #(
    parameter int unsigned HOLD_CYCLES = 6250000
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               level,
    input  logic                               enable,
    output logic [$clog2(HOLD_CYCLES+1)-1:0]   count,
    output logic                               fire
);

    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

    logic armed;

    // Hold counter; re-arms only when the button is released.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            armed <= 1'b1;
            fire  <= 1'b0;
        end else begin
            fire <= 1'b0;
            if (!level) begin
                count <= '0;
                armed <= 1'b1;
            end else if (!enable) begin
                count <= '0;
            end else if (armed) begin
                if (count == LAST) begin
                    fire  <= 1'b1;
                    armed <= 1'b0;
                    count <= '0;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/menu_state_ctrl.sv
// Menu / app state controller.
// Enters the highlighted app on confirm and returns to the menu on back or on
// an app request. Every transition passes through a blanking window of
// SETTLE_CYCLES cycles during which the state code reads 0xF and 'blank' is
// high, so the display never shows a half-drawn frame.
// Build option: LONG_PRESS_EXIT_EN -- back requires holding btnL_level for
// LONG_PRESS_CYCLES cycles instead of a single btnL_pulse.
// Ports:
//   CLOCK, reset : clock and synchronous active-high reset
//   menu_sel     : highlighted menu item 0..3
//   btnC_pulse   : confirm pulse
//   btnL_pulse   : back pulse (ignored with LONG_PRESS_EXIT_EN)
//   btnL_level   : back button level (used only with LONG_PRESS_EXIT_EN)
//   app_done     : app requests return to the menu
//   state        : 0x0 menu, 0x1..0x4 app, 0xF transit (registered)
//   blank        : high during transit (registered)
//   state_chg    : one-cycle pulse when state settles on a new value (registered)
module menu_state_ctrl
    import menu_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES     = 1024,
    parameter int unsigned LONG_PRESS_CYCLES = 6250000
) (
    input  logic       CLOCK,
    input  logic       reset,
    input  logic [1:0] menu_sel,
    input  logic       btnC_pulse,
    input  logic       btnL_pulse,
    input  logic       btnL_level,
    input  logic       app_done,
    output logic [3:0] state,
    output logic       blank,
    output logic       state_chg
);

    localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    fsm_t              fsm_q, fsm_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        sel_q, sel_d;
    logic [3:0]        state_d;
    logic              blank_d;
    logic              state_chg_d;
    logic              exit_evt_c;

`ifdef LONG_PRESS_EXIT_EN
    localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

    logic              hold_fire;
    logic [HOLD_W-1:0] unused_hold_count;
    logic              unused_btn_c;

    press_hold_timer #(
        .HOLD_CYCLES (LONG_PRESS_CYCLES)
    ) u_hold (
        .clk    (CLOCK),
        .reset  (reset),
        .level  (btnL_level),
        .enable (fsm_q == APP),
        .count  (unused_hold_count),
        .fire   (hold_fire)
    );

    assign exit_evt_c   = hold_fire | app_done;
    assign unused_btn_c = btnL_pulse;
`else
    logic unused_btn_c;

    assign exit_evt_c   = btnL_pulse | app_done;
    assign unused_btn_c = ^{btnL_level, 32'(LONG_PRESS_CYCLES)};
`endif

    // State, counter and output registers.
    always_ff @(posedge CLOCK) begin
        if (reset) begin
            fsm_q     <= MENU;
            cnt_q     <= '0;
            sel_q     <= '0;
            state     <= ST_MENU;
            blank     <= 1'b0;
            state_chg <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            state     <= state_d;
            blank     <= blank_d;
            state_chg <= state_chg_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        fsm_d       = fsm_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        state_d     = state;
        blank_d     = blank;
        state_chg_d = 1'b0;

        unique case (fsm_q)
            MENU: begin
                if (btnC_pulse) begin
                    sel_d   = menu_sel;
                    cnt_d   = '0;
                    fsm_d   = ENTER;
                    state_d = ST_TRANSIT;
                    blank_d = 1'b1;
                end
            end
            ENTER: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d       = '0;
                    fsm_d       = APP;
                    state_d     = app_code(sel_q);
                    blank_d     = 1'b0;
                    state_chg_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            APP: begin
                // Back and app_done together still yield a single exit.
                if (exit_evt_c) begin
                    cnt_d   = '0;
                    fsm_d   = EXIT;
                    state_d = ST_TRANSIT;
                    blank_d = 1'b1;
                end
            end
            EXIT: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d       = '0;
                    fsm_d       = MENU;
                    state_d     = ST_MENU;
                    blank_d     = 1'b0;
                    state_chg_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                fsm_d = MENU;
            end
        endcase
    end

endmodule
